// File: rtl/instr_fetch.sv
// Fetch stage: PC, single-outstanding imem request FSM and a 2-entry buffer of {word, pc}.
// Taken branches flush the buffer; an epoch bit marks in-flight responses stale.
`timescale 1ns/1ps
module instr_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [3:0]        condicion,
  output logic [1:0]        operation,
  output logic [5:0]        opcodes,
  output logic [31:0]       inst_word,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              selPC
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [1:0]          count_q, count_d;
  logic                outstanding_q, outstanding_d;
  logic                epoch_q, epoch_d;
  logic                gnt_epoch_q, gnt_epoch_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic [31:0]         word_q [2];
  logic [ADDR_W-1:0]   addr_q [2];

  logic [31:0]         head_word;
  logic [ADDR_W-1:0]   head_addr;
  logic [25:0]         br_off;
  logic [ADDR_W-1:0]   target;
  logic                pop;
  logic                redirect;
  logic                gnt;
  logic                rsp;
  logic                push;
  logic [2:0]          occupancy;

  assign head_word = word_q[rd_ptr_q];
  assign head_addr = addr_q[rd_ptr_q];

  assign inst_valid = (count_q != 2'd0);
  assign inst_word  = inst_valid ? head_word : '0;
  assign inst_pc    = inst_valid ? head_addr : '0;
  assign condicion  = inst_word[31:28];
  assign operation  = inst_word[27:26];
  assign opcodes    = inst_word[25:20];

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = {pc_q[ADDR_W-1:2], 2'b00};

  assign pop      = inst_valid && inst_ready;
  assign redirect = pop && selPC;
  assign br_off   = {head_word[23:0], 2'b00};
  assign target   = head_addr + ADDR_W'(8) + ADDR_W'($signed(br_off));

  assign gnt       = (state_q == S_REQ) && imem_gnt;
  assign rsp       = imem_rvalid && outstanding_q;
  // A redirect in the same cycle wins over the response even when its epoch still matches.
  assign push      = rsp && (gnt_epoch_q == epoch_q) && !redirect;
  assign occupancy = {1'b0, count_q} + {2'b00, outstanding_q};

  always_comb begin
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    outstanding_d = outstanding_q;
    epoch_d       = epoch_q;
    gnt_epoch_d   = gnt_epoch_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    if (gnt) begin
      pc_d          = pc_q + ADDR_W'(4);
      req_addr_d    = pc_q;
      outstanding_d = 1'b1;
      gnt_epoch_d   = epoch_q;
    end else if (rsp) begin
      outstanding_d = 1'b0;
    end

    if (redirect) begin
      pc_d     = target;
      epoch_d  = ~epoch_q;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (redirect || (occupancy < 3'd2)) state_d = S_REQ;
      end
      S_REQ: begin
        // A grant coinciding with a redirect still owes a (stale) response.
        if (gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rsp) state_d = (count_d < 2'd2) ? S_REQ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      req_addr_q    <= '0;
      count_q       <= 2'd0;
      outstanding_q <= 1'b0;
      epoch_q       <= 1'b0;
      gnt_epoch_q   <= 1'b0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      word_q[0]     <= '0;
      word_q[1]     <= '0;
      addr_q[0]     <= '0;
      addr_q[1]     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      epoch_q       <= epoch_d;
      gnt_epoch_q   <= gnt_epoch_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      if (push) begin
        word_q[wr_ptr_q] <= imem_rdata;
        addr_q[wr_ptr_q] <= req_addr_q;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: behavioural imem with variable latency and a program-order fetch model.
`timescale 1ns/1ps
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [3:0]  condicion;
  logic [1:0]  operation;
  logic [5:0]  opcodes;
  logic [31:0] inst_word;
  logic [31:0] inst_pc;
  logic        selPC;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int mem_lat = 1;
  int gnt_pct = 100;
  bit gnt_en = 1'b1;
  int pend_due[$];
  logic [31:0] pend_dat[$];
  logic [31:0] ovr [logic [31:0]];

  logic [31:0] exp_pc, redir_tgt, stab_pc, stab_word;
  bit stab_pending, redir_prev;
  int first_gnt, first_valid, last_rv_cyc, n_gnt, n_cons;

  instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .condicion  (condicion),
    .operation  (operation),
    .opcodes    (opcodes),
    .inst_word  (inst_word),
    .inst_pc    (inst_pc),
    .selPC      (selPC)
  );

  always #5 clk = ~clk;

  // Memory image: hashed words whose branch offset stays within +-8 words.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    int off;
    if (ovr.exists(a)) return ovr[a];
    h = a * 32'h9E3779B1;
    h = h ^ (h >> 15);
    off = int'(h[7:0] % 8'd17) - 8;
    return {h[31:24], 24'(off)};
  endfunction

  function automatic int sext24(input logic [31:0] w);
    return w[23] ? int'(w[23:0]) - 16777216 : int'(w[23:0]);
  endfunction

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: bound expired, observed no event, expected event", tag);
  endtask

  task automatic model_clear();
    exp_pc       = 32'h0;
    stab_pending = 1'b0;
    redir_prev   = 1'b0;
    first_gnt    = -1;
    first_valid  = -1;
    n_gnt        = 0;
    n_cons       = 0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    inst_ready  = 1'b0;
    selPC       = 1'b0;
    pend_due.delete();
    pend_dat.delete();
    model_clear();
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive memory/consumer inputs, check outputs against the model, advance.
  task automatic tick(input bit rdy, input bit sel);
    logic [31:0] w;
    int due;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom();
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend_dat.pop_front();
      void'(pend_due.pop_front());
      last_rv_cyc = cyc;
    end
    imem_gnt = 1'b0;
    if (imem_req && gnt_en && ($urandom_range(99) < gnt_pct)) begin
      imem_gnt = 1'b1;
      n_gnt++;
      due = cyc + mem_lat;
      if (pend_due.size() > 0 && due <= pend_due[$]) due = pend_due[$] + 1;
      pend_due.push_back(due);
      pend_dat.push_back(mem_word(imem_addr));
      if (first_gnt < 0) first_gnt = cyc;
    end
    inst_ready = rdy;
    selPC      = sel;

    if (imem_req) check("addr_align", 96'(imem_addr[1:0]), 96'(0));
    if (stab_pending) begin
      check("stable_valid", 96'(inst_valid), 96'(1));
      check("stable_pc", 96'(inst_pc), 96'(stab_pc));
      check("stable_word", 96'(inst_word), 96'(stab_word));
    end
    if (redir_prev) begin
      check("redir_valid_low", 96'(inst_valid), 96'(0));
      if (imem_req) check("redir_addr", 96'(imem_addr), 96'(redir_tgt));
    end
    if (!inst_valid) begin
      check("empty_fields", 96'({condicion, operation, opcodes}), 96'(0));
      check("empty_word_pc", 96'({inst_word, inst_pc}), 96'(0));
    end
    if (inst_valid && first_valid < 0) first_valid = cyc;

    redir_prev = 1'b0;
    if (inst_valid && rdy) begin
      w = mem_word(exp_pc);
      check("inst_pc", 96'(inst_pc), 96'(exp_pc));
      check("inst_word", 96'(inst_word), 96'(w));
      check("fields", 96'({condicion, operation, opcodes}), 96'({w[31:28], w[27:26], w[25:20]}));
      n_cons++;
      if (sel) begin
        redir_tgt  = exp_pc + 32'd8 + 32'(sext24(w) * 4);
        exp_pc     = redir_tgt;
        redir_prev = 1'b1;
      end else begin
        exp_pc = exp_pc + 32'd4;
      end
    end
    stab_pending = inst_valid && !rdy;
    stab_pc      = inst_pc;
    stab_word    = inst_word;

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_until_head(input logic [31:0] pc, input int limit);
    int n = 0;
    while (!(inst_valid && inst_pc == pc) && n < limit) begin
      tick(1'b1, 1'b0);
      n++;
    end
    if (n >= limit) timeout("head_wait");
  endtask

  task automatic wait_valid(input int limit);
    int n = 0;
    while (!inst_valid && n < limit) begin
      tick(1'b0, 1'b0);
      n++;
    end
    if (n >= limit) timeout("valid_wait");
  endtask

  initial begin
    int n;
    int rdy_pct;
    int br_pct;

    // Reset values, asynchronously applied.
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    inst_ready = 1'b0; selPC = 1'b0;
    #2;
    check("rst_req", 96'(imem_req), 96'(0));
    check("rst_addr", 96'(imem_addr), 96'(0));
    check("rst_valid", 96'(inst_valid), 96'(0));
    check("rst_fields", 96'({condicion, operation, opcodes}), 96'(0));
    check("rst_word_pc", 96'({inst_word, inst_pc}), 96'(0));

    // Sequential fetch from reset with a 1-cycle memory.
    mem_lat = 1; gnt_pct = 100; gnt_en = 1'b1;
    do_reset();
    check("idle_after_rst", 96'(imem_req), 96'(0));
    tick(1'b1, 1'b0);
    check("first_req", 96'(imem_req), 96'(1));
    check("first_addr", 96'(imem_addr), 96'(0));
    repeat (30) tick(1'b1, 1'b0);
    check("gnt_to_valid", 96'(first_valid - first_gnt), 96'(2));
    check("throughput", 96'(n_cons), 96'(14));

    // Backpressure: exactly two buffered, then drain in order.
    do_reset();
    repeat (16) tick(1'b0, 1'b0);
    check("bp_grants", 96'(n_gnt), 96'(2));
    check("bp_req_low", 96'(imem_req), 96'(0));
    check("bp_valid", 96'(inst_valid), 96'(1));
    check("bp_head", 96'(inst_pc), 96'(0));
    repeat (20) tick(1'b1, 1'b0);
    check("bp_drain", 96'(n_cons >= 4), 96'(1));

    // Forward taken branch at 0x10 with 0x14 buffered behind it.
    ovr[32'h10] = 32'hE2000004;
    do_reset();
    run_until_head(32'h10, 40);
    repeat (6) tick(1'b0, 1'b0);
    tick(1'b1, 1'b1);
    check("br_req", 96'(imem_req), 96'(1));
    check("br_addr", 96'(imem_addr), 96'(32'h28));
    check("br_flush", 96'(inst_valid), 96'(0));
    wait_valid(20);
    check("br_next_pc", 96'(inst_pc), 96'(32'h28));
    repeat (10) tick(1'b1, 1'b0);

    // Backward branch to itself, redirect coincident with a response.
    ovr[32'h20] = 32'h0AFFFFFE;
    do_reset();
    run_until_head(32'h20, 60);
    tick(1'b0, 1'b0);
    check("bw_coincident", 96'(pend_due.size() > 0 && pend_due[0] <= cyc), 96'(1));
    tick(1'b1, 1'b1);
    wait_valid(20);
    check("bw_next_pc", 96'(inst_pc), 96'(32'h20));
    repeat (12) tick(1'b1, 1'b0);

    // Redirect while waiting on a 3-cycle memory.
    ovr[32'h08] = 32'h1A000010;
    mem_lat = 3;
    do_reset();
    run_until_head(32'h08, 60);
    tick(1'b0, 1'b0);
    check("wait_state", 96'(imem_req), 96'(0));
    tick(1'b1, 1'b1);
    n = 0;
    while (!imem_req && n < 10) begin
      tick(1'b0, 1'b0);
      n++;
    end
    if (n >= 10) timeout("wait_redir_req");
    check("wait_req_after_stale", 96'(cyc), 96'(last_rv_cyc + 1));
    check("wait_target", 96'(imem_addr), 96'(32'h50));
    wait_valid(20);
    check("wait_next_pc", 96'(inst_pc), 96'(32'h50));
    repeat (10) tick(1'b1, 1'b0);

    // Reset asserted in the middle of a fetch; the late response must be ignored.
    mem_lat = 3;
    do_reset();
    repeat (7) tick(1'b0, 1'b0);
    check("mid_pre_valid", 96'(inst_valid), 96'(1));
    check("mid_pre_wait", 96'(imem_req), 96'(0));
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", 96'(imem_req), 96'(0));
    check("mid_rst_addr", 96'(imem_addr), 96'(0));
    check("mid_rst_valid", 96'(inst_valid), 96'(0));
    check("mid_rst_word_pc", 96'({inst_word, inst_pc}), 96'(0));
    model_clear();
    gnt_en = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
    tick(1'b0, 1'b0);
    check("late_rvalid_seen", 96'(last_rv_cyc), 96'(cyc - 1));
    check("late_rvalid_ignored", 96'(inst_valid), 96'(0));
    repeat (3) tick(1'b0, 1'b0);
    check("late_rvalid_still", 96'(inst_valid), 96'(0));
    gnt_en = 1'b1;
    repeat (20) tick(1'b1, 1'b0);
    check("post_rst_fetch", 96'(n_cons >= 3), 96'(1));

    // Randomised latency, grant delay, backpressure and branches.
    do_reset();
    for (int r = 0; r < 6; r++) begin
      mem_lat = $urandom_range(3, 1);
      gnt_pct = $urandom_range(100, 40);
      rdy_pct = $urandom_range(100, 30);
      br_pct  = 15;
      repeat (400) tick($urandom_range(99) < rdy_pct, $urandom_range(99) < br_pct);
    end
    check("random_progress", 96'(n_cons >= 60), 96'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
